// File: rtl/mem_pkg.sv
// Shared types and helpers for param_memory_module and its clear sequencer.
// The parity helper is only called when MEM_PARITY_EN is defined.
package mem_pkg;

  // Sweep-clear controller states
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int PARITY_MAX_W = 64;

  // Even parity bit: makes the XOR of data plus parity bit equal zero.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/clear_sequencer.sv
// Sweep-clear controller: walks a pointer across every address, one word per
// cycle, and tells the array logic which word to zero. busy is high for
// exactly DEPTH cycles after a clear request is accepted in IDLE.
module clear_sequencer
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  busy_q;

  // FSM and sweep pointer; reset aborts any sweep in progress
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          ptr_q <= ptr_q + ADDR_WIDTH'(1);
          if (ptr_q == LAST_ADDR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/param_memory_module.sv
// Parameterised single-port synchronous RAM with registered read, valid and
// conflict strobes, and a multi-cycle sweep-clear engine.
// Optional build macro MEM_PARITY_EN: stores an even-parity bit per word and
// adds the parity_err output, which pulses with valid on a parity mismatch.
module param_memory_module
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  chip_select,
  input  logic                  rE,
  input  logic                  wE,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  valid,
  output logic                  busy,
  output logic                  conflict
`ifdef MEM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  logic [WORD_W-1:0]     mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;
  logic                  conflict_q;

  logic                  seq_busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  access_ok;
  logic                  rd_en;
  logic                  wr_en;
  logic [WORD_W-1:0]     wr_word;
  logic [WORD_W-1:0]     rd_word;

  clear_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_sequencer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (clear),
    .busy_o    (seq_busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  // A clear request or an active sweep swallows any access in that cycle.
  assign access_ok = chip_select && !clear && !seq_busy;
  assign rd_en     = access_ok && rE;
  assign wr_en     = access_ok && wE;
  assign rd_word   = mem_q[address];

`ifdef MEM_PARITY_EN
  assign wr_word = {even_parity(PARITY_MAX_W'(data)), data};
`else
  assign wr_word = data;
`endif

  // Array writes (sweep or user) and registered read-first port
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q     <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      valid_q    <= rd_en;
      conflict_q <= rd_en && wr_en;
      if (rd_en) begin
        dout_q <= rd_word[DATA_WIDTH-1:0];
      end
      if (clr_we) begin
        mem_q[clr_addr] <= '0;
      end else if (wr_en) begin
        mem_q[address] <= wr_word;
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic parity_err_q;

  // Parity check on the word being read, aligned with valid
  always_ff @(posedge clock) begin
    if (!reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= rd_en &&
        (rd_word[DATA_WIDTH] != even_parity(PARITY_MAX_W'(rd_word[DATA_WIDTH-1:0])));
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign dataOut  = dout_q;
  assign valid    = valid_q;
  assign busy     = seq_busy;
  assign conflict = conflict_q;

endmodule

// File: doc/param_memory_module.md
Name: param_memory_module

Overview:
Parameterised single-port synchronous RAM: generalised successor of the fixed 8x8 memory block, sized by data width and address width. Adds a registered read with a one-cycle `valid` strobe, detection of read/write conflicts, and a multi-cycle sweep-clear engine with a `busy` flag. Used as the general storage element in the lab datapaths, behind a chip-select decoder.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 3, address width; depth DEPTH = 2**ADDR_WIDTH (derived localparam, not overridable)

Ports:
clock  input  1  rising-edge clock; single clock domain
reset  input  1  synchronous, active-low reset
data  input  DATA_WIDTH  write data
address  input  ADDR_WIDTH  read/write address
chip_select  input  1  enables rE/wE when 1
rE  input  1  read enable
wE  input  1  write enable
clear  input  1  request sweep-clear of entire array
dataOut  output  DATA_WIDTH  registered read data
valid  output  1  one-cycle pulse: dataOut updated by a read
busy  output  1  high while sweep-clear in progress
conflict  output  1  one-cycle pulse: rE and wE both asserted with chip_select

Behaviour:
- Reset (reset==0 at rising edge) dominates all inputs. It zeroes every memory word, dataOut, valid, busy, conflict and the sweep pointer, and puts the FSM in IDLE. Reset asserted mid-sweep aborts the sweep.
- FSM states: IDLE, CLEAR.
- IDLE, clear==1: next state CLEAR, sweep pointer = 0, busy = 1 from the next cycle. Any rE/wE in that cycle is dropped; valid = 0, conflict = 0.
- CLEAR: each cycle write 0 to mem[ptr] and increment ptr. On the cycle ptr==DEPTH-1, write that word and return to IDLE; busy = 0 from the next cycle. The sweep takes exactly DEPTH cycles with busy high.
- During CLEAR, rE/wE/clear are ignored, valid = 0, conflict = 0, and dataOut holds its value.
- IDLE, chip_select==0: no access; valid = 0, conflict = 0, dataOut holds.
- IDLE, chip_select==1, clear==0:
  - wE only: mem[address] <= data at the edge; valid = 0.
  - rE only: dataOut <= mem[address] at the edge; valid = 1 for that one cycle. Latency is 1 cycle from the sampled request.
  - rE & wE: read-first. dataOut <= old mem[address], write performed, valid = 1, conflict = 1 (single cycle).
  - Neither: valid = 0.
- Back-to-back reads: valid stays high every cycle a read is accepted.
- Address wrap: the pointer and address are exactly ADDR_WIDTH bits, so there is no out-of-range access.

Optional Feature:
MEM_PARITY_EN
- Defined:
  - Each word stores DATA_WIDTH+1 bits, with even parity computed on write.
  - Adds output port parity_err (1 bit). It pulses with valid when the stored parity mismatches the stored data.
  - Sweep-clear and reset write parity 0.
- Undefined: no parity storage and no parity_err port; behaviour is otherwise identical.

Decomposition:
- Package mem_pkg: state enum {IDLE, CLEAR}, a default-width localparam, and the parity function.
- One sub-module, clear_sequencer: holds the FSM and sweep pointer. It outputs busy, clr_we and clr_addr to the array logic.

Test Plan:
- Reset and write/read: hold reset=0 for 2 cycles, then reset=1. Write data=8'hA5 at addr 3 (cs=1, wE=1), then read addr 3 -> dataOut=8'hA5, valid=1 one cycle later; addr 4 reads 8'h00.
- Chip select off: cs=0, wE=1, data=8'h3C, addr 2; then cs=1 read addr 2 -> dataOut=8'h00, and no valid during the cs=0 cycle.
- Conflict: preload addr 5=8'h11, then cs=1, rE=wE=1, data=8'h22 -> dataOut=8'h11, valid=1, conflict=1. A following read of addr 5 returns 8'h22 with conflict=0.
- Sweep clear: fill all 8 addresses with 8'hFF, pulse clear -> busy high for exactly 8 cycles. rE requests during the sweep give valid=0. Afterwards, all addresses read 8'h00.
- Reset mid-operation: start a sweep, assert reset=0 at cycle 3 -> busy=0 on the next edge, FSM IDLE, all words 8'h00. Also cover a read issued with reset low -> valid=0, dataOut=0.
- Parity (MEM_PARITY_EN): write 8'h07 and read it back -> parity_err=0. Force a stored bit flip in the bench, then read -> parity_err=1 coincident with valid.
